// File: rtl/line_draw_sequencer.sv
// Frame sequencer for the draw_lines engine: buffers segments in a FIFO, clears the frame buffer
// on each frame request, then issues segments one at a time. Optional macro LINE_SEQ_CLIP_EN clamps coordinates to the screen.
module line_draw_sequencer #(
  parameter int P_X_COORD_W  = 11,
  parameter int P_Y_COORD_W  = 11,
  parameter int P_SCREEN_W   = 640,
  parameter int P_SCREEN_H   = 480,
  parameter int P_LOG2_DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_seg_valid,
  output logic                    o_seg_ready,
  input  logic [P_X_COORD_W-1:0]  i_seg_x0,
  input  logic [P_X_COORD_W-1:0]  i_seg_x1,
  input  logic [P_Y_COORD_W-1:0]  i_seg_y0,
  input  logic [P_Y_COORD_W-1:0]  i_seg_y1,
  input  logic                    i_frame_start,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic [P_LOG2_DEPTH:0]   o_seg_count,
  output logic [P_X_COORD_W-1:0]  o_x0,
  output logic [P_X_COORD_W-1:0]  o_x1,
  output logic [P_Y_COORD_W-1:0]  o_y0,
  output logic [P_Y_COORD_W-1:0]  o_y1,
  output logic                    o_draw_start,
  output logic                    o_clear_buffer,
  input  logic                    i_engine_waiting
);

  localparam int DEPTH = 1 << P_LOG2_DEPTH;
  localparam int SEG_W = 2 * P_X_COORD_W + 2 * P_Y_COORD_W;
  localparam logic [P_LOG2_DEPTH:0] FULL_CNT = (P_LOG2_DEPTH+1)'(DEPTH);
  localparam logic [P_X_COORD_W-1:0] X_MAX = P_X_COORD_W'(P_SCREEN_W - 1);
  localparam logic [P_Y_COORD_W-1:0] Y_MAX = P_Y_COORD_W'(P_SCREEN_H - 1);
`ifdef LINE_SEQ_CLIP_EN
  localparam logic CLIP_EN = 1'b1;
`else
  localparam logic CLIP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CLEAR      = 3'd1,
    S_CLEAR_WAIT = 3'd2,
    S_LOAD       = 3'd3,
    S_ISSUE      = 3'd4,
    S_GUARD      = 3'd5,
    S_DRAW_WAIT  = 3'd6,
    S_DONE       = 3'd7
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic [SEG_W-1:0]        fifo_mem_r [DEPTH];
  logic [P_LOG2_DEPTH-1:0] wr_ptr_r;
  logic [P_LOG2_DEPTH-1:0] rd_ptr_r;
  logic [P_LOG2_DEPTH:0]   fifo_cnt_r;
  logic [P_LOG2_DEPTH:0]   fifo_cnt_next_s;
  logic                    seg_ready_r;
  logic                    push_s;
  logic                    pop_s;
  logic                    empty_s;
  logic                    pending_r;
  logic                    guard_done_r;
  logic [SEG_W-1:0]        head_s;
  logic [P_X_COORD_W-1:0]  head_x0_s;
  logic [P_X_COORD_W-1:0]  head_x1_s;
  logic [P_Y_COORD_W-1:0]  head_y0_s;
  logic [P_Y_COORD_W-1:0]  head_y1_s;

  logic                    busy_r;
  logic                    frame_done_r;
  logic                    draw_start_r;
  logic                    clear_buffer_r;
  logic [P_LOG2_DEPTH:0]   seg_count_r;
  logic [P_X_COORD_W-1:0]  x0_r;
  logic [P_X_COORD_W-1:0]  x1_r;
  logic [P_Y_COORD_W-1:0]  y0_r;
  logic [P_Y_COORD_W-1:0]  y1_r;
  logic                    busy_next_s;
  logic                    frame_done_next_s;
  logic                    draw_start_next_s;
  logic                    clear_buffer_next_s;

  function automatic logic [P_X_COORD_W-1:0] clip_x(input logic [P_X_COORD_W-1:0] v);
    if (CLIP_EN && (v > X_MAX)) begin
      return X_MAX;
    end else begin
      return v;
    end
  endfunction

  function automatic logic [P_Y_COORD_W-1:0] clip_y(input logic [P_Y_COORD_W-1:0] v);
    if (CLIP_EN && (v > Y_MAX)) begin
      return Y_MAX;
    end else begin
      return v;
    end
  endfunction

  assign empty_s = (fifo_cnt_r == (P_LOG2_DEPTH+1)'(0));
  assign push_s  = i_seg_valid && seg_ready_r;
  assign pop_s   = (state_r == S_LOAD) && !empty_s;
  assign head_s  = fifo_mem_r[rd_ptr_r];
  assign {head_x0_s, head_y0_s, head_x1_s, head_y1_s} = head_s;

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    fifo_cnt_next_s = fifo_cnt_r;
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_next_s = fifo_cnt_r + (P_LOG2_DEPTH+1)'(1);
      2'b01:   fifo_cnt_next_s = fifo_cnt_r - (P_LOG2_DEPTH+1)'(1);
      default: fifo_cnt_next_s = fifo_cnt_r;
    endcase
  end

  // FIFO pointers, occupancy and ready flag
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      fifo_cnt_r  <= '0;
      seg_ready_r <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + P_LOG2_DEPTH'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + P_LOG2_DEPTH'(1);
      fifo_cnt_r  <= fifo_cnt_next_s;
      seg_ready_r <= (fifo_cnt_next_s != FULL_CNT);
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge i_clk) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= {i_seg_x0, i_seg_y0, i_seg_x1, i_seg_y1};
  end

  // State register, collapsed frame request and clear-wait guard cycle
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_r      <= S_IDLE;
      pending_r    <= 1'b0;
      guard_done_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      guard_done_r <= (state_r == S_CLEAR_WAIT);
      if ((state_r == S_IDLE) && (state_next_s == S_CLEAR)) begin
        pending_r <= 1'b0;
      end else if (i_frame_start && (state_r != S_IDLE)) begin
        pending_r <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (i_frame_start || pending_r) state_next_s = S_CLEAR;
        else                            state_next_s = S_IDLE;
      end
      S_CLEAR:      state_next_s = S_CLEAR_WAIT;
      S_CLEAR_WAIT: begin
        if (guard_done_r && i_engine_waiting) state_next_s = S_LOAD;
        else                                  state_next_s = S_CLEAR_WAIT;
      end
      S_LOAD: begin
        if (empty_s) state_next_s = S_DONE;
        else         state_next_s = S_ISSUE;
      end
      S_ISSUE:      state_next_s = S_GUARD;
      S_GUARD:      state_next_s = S_DRAW_WAIT;
      S_DRAW_WAIT: begin
        if (i_engine_waiting) state_next_s = S_LOAD;
        else                  state_next_s = S_DRAW_WAIT;
      end
      S_DONE:       state_next_s = S_IDLE;
      default:      state_next_s = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output comes straight from a flop
  always_comb begin
    busy_next_s         = 1'b0;
    frame_done_next_s   = 1'b0;
    draw_start_next_s   = 1'b0;
    clear_buffer_next_s = 1'b0;
    case (state_next_s)
      S_IDLE:  busy_next_s = 1'b0;
      S_CLEAR: begin
        busy_next_s         = 1'b1;
        clear_buffer_next_s = 1'b1;
      end
      S_ISSUE: begin
        busy_next_s       = 1'b1;
        draw_start_next_s = 1'b1;
      end
      S_DONE: begin
        busy_next_s       = 1'b1;
        frame_done_next_s = 1'b1;
      end
      default: busy_next_s = 1'b1;
    endcase
  end

  // Output registers; coordinates load only on a pop
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      busy_r         <= 1'b0;
      frame_done_r   <= 1'b0;
      draw_start_r   <= 1'b0;
      clear_buffer_r <= 1'b0;
      seg_count_r    <= '0;
      x0_r           <= '0;
      x1_r           <= '0;
      y0_r           <= '0;
      y1_r           <= '0;
    end else begin
      busy_r         <= busy_next_s;
      frame_done_r   <= frame_done_next_s;
      draw_start_r   <= draw_start_next_s;
      clear_buffer_r <= clear_buffer_next_s;
      if (state_next_s == S_CLEAR) begin
        seg_count_r <= '0;
      end else if (state_next_s == S_ISSUE) begin
        seg_count_r <= seg_count_r + (P_LOG2_DEPTH+1)'(1);
      end
      if (pop_s) begin
        x0_r <= clip_x(head_x0_s);
        x1_r <= clip_x(head_x1_s);
        y0_r <= clip_y(head_y0_s);
        y1_r <= clip_y(head_y1_s);
      end
    end
  end

  assign o_seg_ready    = seg_ready_r;
  assign o_busy         = busy_r;
  assign o_frame_done   = frame_done_r;
  assign o_draw_start   = draw_start_r;
  assign o_clear_buffer = clear_buffer_r;
  assign o_seg_count    = seg_count_r;
  assign o_x0           = x0_r;
  assign o_x1           = x1_r;
  assign o_y0           = y0_r;
  assign o_y1           = y1_r;

endmodule

// File: tb/tb_line_draw_sequencer.sv
// Randomised scoreboard bench for line_draw_sequencer: a queue-based segment model predicts draws and frame counts.
module tb_line_draw_sequencer;
  localparam int XW    = 11;
  localparam int YW    = 11;
  localparam int LD    = 4;
  localparam int DEPTH = 16;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;

  typedef struct packed {
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y1;
  } seg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          seg_valid;
  logic [XW-1:0] sx0, sx1;
  logic [YW-1:0] sy0, sy1;
  logic          frame_start;
  logic          engine_waiting = 1'b1;
  logic          o_seg_ready, o_busy, o_frame_done, o_draw_start, o_clear_buffer;
  logic [LD:0]   o_seg_count;
  logic [XW-1:0] o_x0, o_x1;
  logic [YW-1:0] o_y0, o_y1;

  line_draw_sequencer dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_seg_valid(seg_valid), .o_seg_ready(o_seg_ready),
    .i_seg_x0(sx0), .i_seg_x1(sx1), .i_seg_y0(sy0), .i_seg_y1(sy1),
    .i_frame_start(frame_start), .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_seg_count(o_seg_count), .o_x0(o_x0), .o_x1(o_x1), .o_y0(o_y0), .o_y1(o_y1),
    .o_draw_start(o_draw_start), .o_clear_buffer(o_clear_buffer),
    .i_engine_waiting(engine_waiting)
  );

  seg_t model_q[$];
  seg_t exp_draw[$];
  int   exp_done[$];
  int   passed = 0, total = 0;
  int   cyc = 0, dones = 0, clears = 0, frames = 0;
  int   slow_mode = 0, busy_cnt = 0;
  int   clear_cyc = 0, last_draw_cyc = 0, draws_in_frame = 0;
  logic in_frame = 1'b0, busy_gap = 1'b0;
  seg_t mon_e;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic seg_t ref_clip(input seg_t s);
    seg_t r = s;
`ifdef LINE_SEQ_CLIP_EN
    if (int'(s.x0) > SCR_W - 1) r.x0 = XW'(SCR_W - 1);
    if (int'(s.x1) > SCR_W - 1) r.x1 = XW'(SCR_W - 1);
    if (int'(s.y0) > SCR_H - 1) r.y0 = YW'(SCR_H - 1);
    if (int'(s.y1) > SCR_H - 1) r.y1 = YW'(SCR_H - 1);
`endif
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor/scoreboard plus engine model
  always @(negedge clk) begin
    if (reset_n) begin
      if (o_clear_buffer) begin
        clears++;
        clear_cyc = cyc;
        draws_in_frame = 0;
        in_frame = 1'b1;
        busy_gap = 1'b0;
      end
      if (in_frame && !o_busy) busy_gap = 1'b1;
      if (o_draw_start) begin
        if (exp_draw.size() == 0) check("unexpected_draw", 1, 0);
        else begin
          mon_e = exp_draw.pop_front();
          check("draw_coords", {o_x0, o_y0, o_x1, o_y1}, {mon_e.x0, mon_e.y0, mon_e.x1, mon_e.y1});
        end
        check("draw_while_engine_busy", busy_cnt, 0);
        if (slow_mode == 0)
          check("draw_spacing", cyc - ((draws_in_frame == 0) ? clear_cyc : last_draw_cyc), 4);
        last_draw_cyc = cyc;
        draws_in_frame++;
      end
      if (o_frame_done) begin
        dones++;
        if (exp_done.size() == 0) check("unexpected_done", 1, 0);
        else check("seg_count", o_seg_count, exp_done.pop_front());
        check("busy_in_frame", busy_gap, 0);
        if (slow_mode == 0) check("frame_len", cyc - clear_cyc, 4 + 4 * draws_in_frame);
        in_frame = 1'b0;
      end
    end
    if (o_draw_start && (slow_mode != 0)) busy_cnt = 50;
    else if (busy_cnt > 0) busy_cnt--;
    engine_waiting = (busy_cnt == 0);
  end

  task automatic push(input seg_t s);
    check("seg_ready", o_seg_ready, (model_q.size() < DEPTH) ? 1 : 0);
    {sx0, sy0, sx1, sy1} = {s.x0, s.y0, s.x1, s.y1};
    seg_valid = 1'b1;
    @(posedge clk);
    #1 seg_valid = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(s);
  endtask

  task automatic push_random(input int n);
    seg_t s;
    for (int i = 0; i < n; i++) begin
      s.x0 = XW'($urandom_range(0, 2047));
      s.y0 = YW'($urandom_range(0, 2047));
      s.x1 = XW'($urandom_range(0, 2047));
      s.y1 = YW'($urandom_range(0, 2047));
      push(s);
    end
  endtask

  task automatic start_frame();
    int n = 0;
    while (model_q.size() > 0) begin
      exp_draw.push_back(ref_clip(model_q.pop_front()));
      n++;
    end
    exp_done.push_back(n);
    frames++;
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    @(negedge clk);
    check("clear_latency", o_clear_buffer, 1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (dones < target && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("done_timeout", (dones >= target) ? 1 : 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d;
    seg_t s;
    reset_n = 1'b0; seg_valid = 1'b0; frame_start = 1'b0;
    sx0 = '0; sx1 = '0; sy0 = '0; sy1 = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset_outputs", {o_busy, o_frame_done, o_seg_count, o_x0, o_y0, o_x1, o_y1, o_draw_start, o_clear_buffer}, 0);
    check("reset_ready", o_seg_ready, 1);
    @(posedge clk); #1;

    // three fixed segments, idle engine
    s = '{x0: 11'd1, y0: 11'd2, x1: 11'd3, y1: 11'd4};        push(s);
    s = '{x0: 11'd100, y0: 11'd200, x1: 11'd300, y1: 11'd400}; push(s);
    s = '{x0: 11'd639, y0: 11'd479, x1: 11'd0, y1: 11'd0};     push(s);
    start_frame();
    wait_done(1);

    // overfill: 17 pushes, 16 kept
    push_random(17);
    check("ready_after_full", o_seg_ready, 0);
    start_frame();
    wait_done(2);
    check("ready_after_drain", o_seg_ready, 1);

    // clip boundary segment
    s = '{x0: 11'd700, y0: 11'd500, x1: 11'd10, y1: 11'd20};
    push(s);
    start_frame();
    wait_done(3);

    // random frames, including empty ones
    for (int f = 0; f < 4; f++) begin
      push_random($urandom_range(0, 10));
      start_frame();
      wait_done(4 + f);
    end

    // slow engine
    slow_mode = 1;
    push_random(3);
    start_frame();
    wait_done(8);
    slow_mode = 0;
    repeat (60) @(posedge clk);
    #1;

    // two requests mid-frame collapse into one extra empty frame
    push_random(2);
    start_frame();
    repeat (2) @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    exp_done.push_back(0);
    frames++;
    wait_done(10);
    repeat (20) @(posedge clk);
    check("no_extra_frame", dones, 10);
    #1;

    // reset during DRAW_WAIT
    slow_mode = 1;
    push_random(3);
    start_frame();
    d = 0;
    while (draws_in_frame < 1 && d < 200) begin
      @(posedge clk);
      d++;
    end
    check("first_draw_timeout", (draws_in_frame >= 1) ? 1 : 0, 1);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    exp_draw.delete();
    exp_done.delete();
    model_q.delete();
    in_frame = 1'b0;
    @(negedge clk);
    check("midreset_outputs", {o_busy, o_frame_done, o_seg_count, o_x0, o_y0, o_x1, o_y1, o_draw_start, o_clear_buffer}, 0);
    check("midreset_ready", o_seg_ready, 1);
    repeat (80) @(posedge clk);
    check("no_done_after_reset", dones, 10);
    slow_mode = 0;
    #1;
    start_frame();
    wait_done(11);

    check("clear_count", clears, frames);
    check("leftover_draws", exp_draw.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/line_draw_sequencer.md
# line_draw_sequencer

Sequencer that owns the `draw_lines` engine on behalf of the 3D motion controller. It buffers line segments pushed by the geometry stage in a small FIFO. On each frame request it clears the engine's frame buffer, then feeds the buffered segments to the engine one at a time, waiting for the engine to go idle between segments. It sits between the projection logic and `draw_lines`; the VGA scan-out path is untouched.

## Interface
- P_X_COORD_W, 11, x coordinate width
- P_Y_COORD_W, 11, y coordinate width
- P_SCREEN_W, 640, screen width in pixels (clip bound)
- P_SCREEN_H, 480, screen height in pixels (clip bound)
- P_LOG2_DEPTH, 4, log2 of segment FIFO depth (default 16 entries)
- i_clk  in  1  system clock
- i_reset_n  in  1  synchronous, active-low reset
- i_seg_valid  in  1  segment push request
- o_seg_ready  out  1  FIFO not full
- i_seg_x0, i_seg_x1  in  P_X_COORD_W each  segment x endpoints
- i_seg_y0, i_seg_y1  in  P_Y_COORD_W each  segment y endpoints
- i_frame_start  in  1  single-cycle frame request
- o_busy  out  1  high in any state other than IDLE
- o_frame_done  out  1  single-cycle pulse at end of frame
- o_seg_count  out  P_LOG2_DEPTH+1  segments issued in current or last frame
- o_x0, o_x1  out  P_X_COORD_W  coordinates to engine
- o_y0, o_y1  out  P_Y_COORD_W  coordinates to engine
- o_draw_start  out  1  single-cycle start pulse to engine
- o_clear_buffer  out  1  single-cycle clear pulse to engine
- i_engine_waiting  in  1  engine idle (`o_waiting` of `draw_lines`)

## Operation
- FIFO: push when i_seg_valid && o_seg_ready; o_seg_ready = !full. Push while full is dropped. Simultaneous push and pop is allowed and leaves the occupancy unchanged. Pop happens only in LOAD.
- States: IDLE, CLEAR, CLEAR_WAIT, LOAD, ISSUE, GUARD, DRAW_WAIT, DONE.
- IDLE: leaves to CLEAR when i_frame_start or the pending flag is set, and clears the pending flag.
- i_frame_start outside IDLE sets the pending flag. Multiple such requests collapse into one.
- CLEAR: o_clear_buffer=1 for 1 cycle; zero o_seg_count; go to CLEAR_WAIT.
- CLEAR_WAIT: one guard cycle, then stay until i_engine_waiting=1; go to LOAD.
- LOAD: if the FIFO is empty, go to DONE. Otherwise pop the head into the o_x0..o_y1 registers and go to ISSUE.
- ISSUE: o_draw_start=1 for 1 cycle; o_seg_count += 1; go to GUARD.
- GUARD: one cycle in which i_engine_waiting is ignored; go to DRAW_WAIT.
- DRAW_WAIT: stay until i_engine_waiting=1; go to LOAD.
- DONE: o_frame_done=1 for 1 cycle; go to IDLE.
- Segments pushed while a frame is in progress are drawn in that frame if they arrive before LOAD finds the FIFO empty.
- o_x0..o_y1 hold their last values between segments. They change only on a pop.

## Timing
- Reset: all outputs 0 except o_seg_ready=1. FIFO empty, pending flag cleared, state IDLE.
- Reset mid-frame: the engine is abandoned and no o_frame_done is issued.
- i_frame_start in IDLE to o_clear_buffer: 1 cycle.
- LOAD to o_draw_start: 1 cycle. The coordinates are stable on the cycle of o_draw_start and afterwards.
- With an always-idle engine, each segment costs 4 cycles (LOAD, ISSUE, GUARD, DRAW_WAIT).
- A frame with 0 segments takes 5 cycles: CLEAR, CLEAR_WAIT×2, LOAD, DONE.
- o_seg_count holds its value after DONE until the next CLEAR.

## Configuration
- LINE_SEQ_CLIP_EN defined: at pop, each coordinate is clamped to [0, P_SCREEN_W-1] or [0, P_SCREEN_H-1] before it is registered.
- LINE_SEQ_CLIP_EN undefined: coordinates pass through unmodified.

## Test plan
- Reset, push 3 segments, then pulse i_frame_start with i_engine_waiting held at 1:
  - one o_clear_buffer pulse, then 3 o_draw_start pulses 4 cycles apart;
  - o_frame_done follows, with o_seg_count=3;
  - o_x0..o_y1 match each segment at its o_draw_start.
- Push 17 segments (default depth 16) with the sequencer idle:
  - o_seg_ready drops after 16 pushes;
  - the 17th push is dropped;
  - a frame then draws exactly 16 segments.
- Engine model holds i_engine_waiting=0 for 50 cycles after each start:
  - no o_draw_start is issued until the engine reports waiting;
  - o_busy stays 1 throughout the frame.
- i_frame_start pulsed twice mid-frame:
  - exactly one additional frame runs after DONE;
  - the second frame starts with a clear and ends with o_seg_count=0 if no new pushes.
- Assert i_reset_n=0 during DRAW_WAIT:
  - next cycle all outputs are 0 and o_seg_ready=1;
  - no o_frame_done is issued;
  - the FIFO is empty.
- With LINE_SEQ_CLIP_EN defined, push segment (x0=700, y0=500, x1=10, y1=20):
  - the engine receives (639, 479, 10, 20);
  - without the macro it receives (700, 500, 10, 20).
